// File: rtl/rr_mux_arbiter.sv
// ---------------------------------------------------------------------------
// rr_mux_arbiter
//
// Shares one 4:1 data mux between four valid/ready/last producer streams and
// forwards the winner into a single registered output stage. Arbitration is
// round-robin between packets; once a multi-beat packet starts, the grant is
// locked to that requester until its last beat is accepted.
//
// Handshake: a beat moves on an interface at a rising clk edge when valid
// and ready are both high in the cycle before that edge. A producer must
// hold valid and its data/last stable until that happens. out_valid never
// depends combinationally on out_ready; in_ready does depend on out_ready.
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   in_valid   per-requester valid, bit i = requester i
//   in_last    per-requester last-beat-of-packet flag
//   d0..d3     requester data, WIDTH bits each
//   in_ready   per-requester ready (combinational, at most one bit set)
//   out_valid  registered output valid
//   out_data   registered selected data
//   out_last   registered last flag of the selected beat
//   out_sel    registered index of the requester that produced out_data
//   out_ready  downstream ready
//   dbg_state  current arbiter state (0 = IDLE, 1 = LOCKED)
// ---------------------------------------------------------------------------
module rr_mux_arbiter #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [3:0]       in_valid,
  input  logic [3:0]       in_last,
  input  logic [WIDTH-1:0] d0,
  input  logic [WIDTH-1:0] d1,
  input  logic [WIDTH-1:0] d2,
  input  logic [WIDTH-1:0] d3,
  output logic [3:0]       in_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  output logic             out_last,
  output logic [1:0]       out_sel,
  input  logic             out_ready,
  output logic             dbg_state
);

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } state_e;

  state_e           state_q, state_d;
  logic [1:0]       ptr_q, ptr_d;
  logic [1:0]       lock_idx_q, lock_idx_d;
  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic             out_last_q, out_last_d;
  logic [1:0]       out_sel_q, out_sel_d;

  logic             load_en;
  logic [1:0]       arb_idx;
  logic [WIDTH-1:0] sel_data;
  logic             sel_last;
  logic             accept;

  // Output register can take a new beat when empty or being drained now.
  assign load_en = !out_valid_q || out_ready;

  // Round-robin scan starting at ptr_q. In LOCKED the lock owner is the only
  // candidate, so other requesters' valid bits cannot disturb the grant.
  always_comb begin
    logic [1:0] c1, c2, c3;
    c1      = ptr_q + 2'd1;
    c2      = ptr_q + 2'd2;
    c3      = ptr_q + 2'd3;
    arb_idx = ptr_q;
    if (state_q == LOCKED) begin
      arb_idx = lock_idx_q;
    end else if (in_valid[ptr_q]) begin
      arb_idx = ptr_q;
    end else if (in_valid[c1]) begin
      arb_idx = c1;
    end else if (in_valid[c2]) begin
      arb_idx = c2;
    end else if (in_valid[c3]) begin
      arb_idx = c3;
    end
  end

  // Data mux: only the granted requester's data and last can propagate.
  always_comb begin
    sel_data = d0;
    case (arb_idx)
      2'd0:    sel_data = d0;
      2'd1:    sel_data = d1;
      2'd2:    sel_data = d2;
      default: sel_data = d3;
    endcase
  end

  assign sel_last = in_last[arb_idx];

  // In LOCKED the owner sees ready even with valid low, so the grant stays
  // visible while the packet stalls. Ready is suppressed during reset.
  always_comb begin
    in_ready = 4'b0000;
    for (int i = 0; i < 4; i++) begin
      in_ready[i] = rst_n && load_en && (arb_idx == 2'(i)) &&
                    ((state_q == LOCKED) || in_valid[i]);
    end
  end

  assign accept = in_valid[arb_idx] && in_ready[arb_idx];

  // Next-state for arbiter and output stage.
  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    lock_idx_d  = lock_idx_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_last_d  = out_last_q;
    out_sel_d   = out_sel_q;

    // When the register may load, out_valid follows accept; data/last/sel
    // keep their previous values if nothing new arrives.
    if (load_en) begin
      out_valid_d = accept;
    end

    if (accept) begin
      out_data_d = sel_data;
      out_last_d = sel_last;
      out_sel_d  = arb_idx;
      case (state_q)
        IDLE: begin
          if (sel_last) begin
            ptr_d = arb_idx + 2'd1;
          end else begin
            state_d    = LOCKED;
            lock_idx_d = arb_idx;
          end
        end
        LOCKED: begin
          if (sel_last) begin
            state_d = IDLE;
            ptr_d   = lock_idx_q + 2'd1;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      ptr_q       <= 2'd0;
      lock_idx_q  <= 2'd0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_last_q  <= 1'b0;
      out_sel_q   <= 2'd0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      lock_idx_q  <= lock_idx_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_last_q  <= out_last_d;
      out_sel_q   <= out_sel_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_last  = out_last_q;
  assign out_sel   = out_sel_q;
  assign dbg_state = (state_q == LOCKED);

endmodule

// File: tb/tb_rr_mux_arbiter.sv
// ---------------------------------------------------------------------------
// tb_rr_mux_arbiter
//
// Self-checking bench for rr_mux_arbiter: a table of single-request vectors
// applied from reset, then hand-written multi-cycle sequences (round robin,
// fairness, packet lock, backpressure, X isolation, mid-packet reset).
// Output beats are checked by a scoreboard queue filled as stimulus is driven.
// ---------------------------------------------------------------------------
module tb_rr_mux_arbiter;
  localparam int WIDTH = 4;
  localparam int W     = WIDTH + 3;   // {sel, last, data}

  logic             clk;
  logic             rst_n;
  logic [3:0]       in_valid;
  logic [3:0]       in_last;
  logic [WIDTH-1:0] d0, d1, d2, d3;
  logic [3:0]       in_ready;
  logic             out_valid;
  logic [WIDTH-1:0] out_data;
  logic             out_last;
  logic [1:0]       out_sel;
  logic             out_ready;
  logic             dbg_state;

  int checks   = 0;
  int failures = 0;
  logic sb_en  = 1'b0;
  logic [W-1:0] exp_q[$];

  rr_mux_arbiter #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_last   (in_last),
    .d0        (d0),
    .d1        (d1),
    .d2        (d2),
    .d3        (d3),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_last  (out_last),
    .out_sel   (out_sel),
    .out_ready (out_ready),
    .dbg_state (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reset with every requester asking; optionally check the reset state.
  task automatic do_reset(input bit chk);
    rst_n    = 1'b0;
    in_valid = 4'b1111;
    in_last  = 4'b1111;
    out_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    if (chk) begin
      check("rst_out_valid", 32'(out_valid), 32'd0);
      check("rst_out_data",  32'(out_data),  32'd0);
      check("rst_out_sel",   32'(out_sel),   32'd0);
      check("rst_in_ready",  32'(in_ready),  32'd0);
    end
    @(posedge clk);
    #1;
    rst_n    = 1'b1;
    in_valid = 4'b0000;
  endtask

  // ---------------- driver tasks ----------------
  function automatic logic [W-1:0] beat(input logic [1:0] sel, input logic last,
                                        input logic [WIDTH-1:0] data);
    return {sel, last, data};
  endfunction

  // Keep the current request pattern until n beats are accepted, then drop
  // all valids. Returns the number of cycles spent.
  task automatic run_accepts(input int n, output int cyc);
    int cnt;
    cnt = 0;
    cyc = 0;
    while (cnt < n && cyc < 200) begin
      @(negedge clk);
      if (|(in_valid & in_ready)) cnt++;
      @(posedge clk);
      #1;
      cyc++;
    end
    in_valid = 4'b0000;
    check("accept_budget", 32'(cnt), 32'(n));
  endtask

  task automatic drain(input string name);
    repeat (3) @(negedge clk);
    check(name, 32'(exp_q.size()), 32'd0);
    exp_q.delete();
    @(posedge clk);
    #1;
  endtask

  // ---------------- scoreboard ----------------
  always @(negedge clk) begin
    if (sb_en && rst_n && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL sb_unexpected: got sel=%0d data=%0h expected no beat", out_sel, out_data);
      end else begin
        check("sb_beat", 32'({out_sel, out_last, out_data}), 32'(exp_q.pop_front()));
      end
    end
  end

  // ---------------- vector table ----------------
  typedef struct {
    logic [3:0]       valid;
    logic [3:0]       r0;     // in_ready before the first edge
    logic             v;      // out_valid after the first edge
    logic [1:0]       sel;
    logic [WIDTH-1:0] data;
    logic [3:0]       r1;     // in_ready after the first edge (ptr moved)
  } vec_t;

  vec_t vecs[7];

  initial begin
    int cyc;
    d0 = 4'd1; d1 = 4'd2; d2 = 4'd3; d3 = 4'd4;
    in_valid = 4'b0000; in_last = 4'b1111; out_ready = 1'b1; rst_n = 1'b0;

    vecs[0] = '{4'b0001, 4'b0001, 1'b1, 2'd0, 4'd1, 4'b0001};
    vecs[1] = '{4'b1010, 4'b0010, 1'b1, 2'd1, 4'd2, 4'b1000};
    vecs[2] = '{4'b1100, 4'b0100, 1'b1, 2'd2, 4'd3, 4'b1000};
    vecs[3] = '{4'b1111, 4'b0001, 1'b1, 2'd0, 4'd1, 4'b0010};
    vecs[4] = '{4'b1001, 4'b0001, 1'b1, 2'd0, 4'd1, 4'b1000};
    vecs[5] = '{4'b0000, 4'b0000, 1'b0, 2'd0, 4'd0, 4'b0000};
    vecs[6] = '{4'b0110, 4'b0010, 1'b1, 2'd1, 4'd2, 4'b0100};

    // ---- table-driven single-beat vectors, each from reset ----
    for (int k = 0; k < 7; k++) begin
      do_reset(k == 0);
      d0 = 4'd1; d1 = 4'd2; d2 = 4'd3; d3 = 4'd4;
      in_last  = 4'b1111;
      in_valid = vecs[k].valid;
      @(negedge clk);
      check($sformatf("vec%0d_ready0", k), 32'(in_ready), 32'(vecs[k].r0));
      @(posedge clk);
      #1;
      @(negedge clk);
      check($sformatf("vec%0d_valid", k), 32'(out_valid), 32'(vecs[k].v));
      check($sformatf("vec%0d_sel",   k), 32'(out_sel),   32'(vecs[k].sel));
      check($sformatf("vec%0d_data",  k), 32'(out_data),  32'(vecs[k].data));
      check($sformatf("vec%0d_ready1", k), 32'(in_ready), 32'(vecs[k].r1));
      @(posedge clk);
      #1;
      in_valid = 4'b0000;
    end

    sb_en = 1'b1;

    // ---- round robin, single beats, 8 beats with no bubbles ----
    do_reset(0);
    d0 = 4'hA; d1 = 4'hB; d2 = 4'hC; d3 = 4'hD;
    in_last = 4'b1111;
    in_valid = 4'b1111;
    for (int k = 0; k < 8; k++) begin
      logic [WIDTH-1:0] dv;
      dv = WIDTH'(4'hA + (k % 4));
      exp_q.push_back(beat(2'(k % 4), 1'b1, dv));
    end
    run_accepts(8, cyc);
    check("rr_cycles", 32'(cyc), 32'd8);
    drain("rr_drain");

    // ---- fairness: requesters 0 and 2 only ----
    do_reset(0);
    d0 = 4'h5; d2 = 4'h6;
    in_last = 4'b1111;
    in_valid = 4'b0101;
    for (int k = 0; k < 6; k++) begin
      if (k % 2 == 0) exp_q.push_back(beat(2'd0, 1'b1, 4'h5));
      else            exp_q.push_back(beat(2'd2, 1'b1, 4'h6));
    end
    run_accepts(6, cyc);
    check("fair_cycles", 32'(cyc), 32'd6);
    drain("fair_drain");

    // ---- packet lock: requester 1 sends 3 beats, requester 0 waits ----
    do_reset(0);
    d0 = 4'h9;
    d1 = 4'h1; in_last = 4'b0000; in_valid = 4'b0010;
    exp_q.push_back(beat(2'd1, 1'b0, 4'h1));
    @(negedge clk);
    check("lock_rdy_b1", 32'(in_ready), 32'b0010);
    @(posedge clk); #1;
    d1 = 4'h2; in_last = 4'b0001; in_valid = 4'b0011;
    exp_q.push_back(beat(2'd1, 1'b0, 4'h2));
    @(negedge clk);
    check("lock_rdy_b2", 32'(in_ready), 32'b0010);
    check("lock_state",  32'(dbg_state), 32'd1);
    @(posedge clk); #1;
    // Lock owner pauses: requester 0 must still be blocked.
    in_valid = 4'b0001;
    @(negedge clk);
    check("lock_rdy_pause", 32'(in_ready), 32'b0010);
    @(posedge clk); #1;
    d1 = 4'h3; in_last = 4'b0011; in_valid = 4'b0011;
    exp_q.push_back(beat(2'd1, 1'b1, 4'h3));
    @(negedge clk);
    check("lock_gap_valid", 32'(out_valid), 32'd0);
    check("lock_rdy_b3",    32'(in_ready),  32'b0010);
    @(posedge clk); #1;
    in_valid = 4'b0001; in_last = 4'b0001;
    exp_q.push_back(beat(2'd0, 1'b1, 4'h9));
    @(negedge clk);
    check("lock_release", 32'(in_ready), 32'b0001);
    @(posedge clk); #1;
    in_valid = 4'b0000;
    drain("lock_drain");

    // ---- backpressure: 3 stalled cycles mid-stream ----
    do_reset(0);
    d0 = 4'hA; d1 = 4'hB; d2 = 4'hC; d3 = 4'hD;
    in_last = 4'b1111;
    in_valid = 4'b1111;
    exp_q.push_back(beat(2'd0, 1'b1, 4'hA));
    exp_q.push_back(beat(2'd1, 1'b1, 4'hB));
    exp_q.push_back(beat(2'd2, 1'b1, 4'hC));
    exp_q.push_back(beat(2'd3, 1'b1, 4'hD));
    run_accepts(2, cyc);
    in_valid  = 4'b1111;
    out_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("bp_valid", 32'(out_valid), 32'd1);
      check("bp_sel",   32'(out_sel),   32'd1);
      check("bp_data",  32'(out_data),  32'hB);
      check("bp_ready", 32'(in_ready),  32'b0000);
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    run_accepts(2, cyc);
    drain("bp_drain");

    // ---- X isolation: d3 unknown, only requester 0 valid ----
    do_reset(0);
    d0 = 4'h7; d3 = 'x;
    in_last = 4'b0001;
    in_valid = 4'b0001;
    exp_q.push_back(beat(2'd0, 1'b1, 4'h7));
    run_accepts(1, cyc);
    @(negedge clk);
    check("x_data", 32'(out_data), 32'h7);
    @(posedge clk); #1;
    drain("x_drain");
    d3 = 4'h4;

    // ---- reset mid-packet: requester 2 locked, then abort ----
    sb_en = 1'b0;
    d2 = 4'h3; in_last = 4'b0000; in_valid = 4'b0100;
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    in_valid = 4'b0000;
    #1;
    check("abort_valid", 32'(out_valid), 32'd0);
    check("abort_data",  32'(out_data),  32'd0);
    check("abort_sel",   32'(out_sel),   32'd0);
    check("abort_ready", 32'(in_ready),  32'd0);
    check("abort_state", 32'(dbg_state), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    sb_en = 1'b1;
    d0 = 4'h1; d1 = 4'h2; d2 = 4'h3; d3 = 4'h4;
    in_last = 4'b1111; in_valid = 4'b1111;
    @(negedge clk);
    check("abort_next_grant", 32'(in_ready), 32'b0001);
    exp_q.push_back(beat(2'd0, 1'b1, 4'h1));
    @(posedge clk); #1;
    in_valid = 4'b0000;
    drain("abort_drain");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Global time limit so the bench always terminates.
  initial begin
    #200000;
    $display("FAIL timeout: got no end of test expected finish");
    $fatal(1);
  end

endmodule

// File: doc/rr_mux_arbiter.md
Name: rr_mux_arbiter

Overview:
- Shares one 4:1 data mux between four requesters, each using a valid/ready/last stream.
- Round-robin arbitration with per-packet grant lock; the winning index drives the mux select.
- One registered output stage; full throughput when the downstream is ready.
- Sits between four producer streams and a single shared downstream consumer.

Parameters:
- WIDTH, default 4, data width of each requester and of the output.

Ports:
- clk  input  1  clock, rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  4  per-requester valid; bit i belongs to requester i.
- in_last  input  4  per-requester last-beat-of-packet flag.
- d0, d1, d2, d3  input  WIDTH each  requester data.
- in_ready  output  4  per-requester ready (combinational).
- out_valid  output  1  registered output valid.
- out_data  output  WIDTH  registered selected data.
- out_last  output  1  registered last flag of the selected beat.
- out_sel  output  2  registered index of the requester that produced out_data.
- out_ready  input  1  downstream ready.

Behaviour:
- Reset (rst_n low, asynchronous): out_valid=0, out_data=0, out_last=0, out_sel=0, state=IDLE, rr pointer ptr=0. in_ready is forced to 4'b0000 while rst_n is low.
- load_en = !out_valid || out_ready (output register empty, or being drained this cycle).
- States:
  - IDLE: arb_idx is the first i with in_valid[i]=1, scanning ptr, ptr+1, ... mod 4. Combinational, no bubble cycle.
  - LOCKED: arb_idx = lock_idx; other requesters are ignored.
- in_ready[i] = load_en && (i == arb_idx) && (state == LOCKED || in_valid[i]). At most one bit is set.
- Accept = in_valid[arb_idx] && in_ready[arb_idx]. On accept at the clock edge:
  - Register the selected data into out_data, in_last[arb_idx] into out_last and arb_idx into out_sel; set out_valid=1.
  - Selected data is d0..d3 chosen by arb_idx.
- Latency is 1 cycle from accept to out_valid. With out_ready held high there is one beat per cycle.
- If out_ready=1 and there is no accept, out_valid goes to 0. out_data, out_last and out_sel hold their last values.
- Transitions:
  - IDLE, accept with last=0: go to LOCKED, lock_idx=arb_idx.
  - IDLE, accept with last=1: stay IDLE, ptr=arb_idx+1 mod 4.
  - LOCKED, accept with last=1: go to IDLE, ptr=lock_idx+1 mod 4.
  - LOCKED, accept with last=0: stay LOCKED.
- LOCKED with the locked requester's valid low: no output beat is produced and other requesters wait. There is no timeout.
- Backpressure: while out_valid=1 and out_ready=0, all output registers are stable and in_ready=0.
- Data isolation: the data, in_last or X value of any non-selected requester must never reach the outputs. Valid and last of non-granted requesters may be X without affecting out_*.
- Reset mid-packet: outputs clear immediately and the state returns to IDLE with ptr=0. The partial packet is dropped and no recovery is attempted.
- ptr wraps 3→0.

Test Plan:
- Reset: hold rst_n=0 with all in_valid=1 → out_valid=0, out_data=0, out_sel=0, in_ready=0000. Also assert rst_n low mid-cycle → outputs clear before the next edge.
- Round robin, single beats: all in_valid=1, in_last=1111, d0..d3=a,b,c,d, out_ready=1 → out_sel 0,1,2,3,0,... and out_data a,b,c,d,a on consecutive cycles, starting 1 cycle after reset release.
- Fairness: only requesters 0 and 2 valid, single beats → out_sel 0,2,0,2,... with no idle cycles.
- Packet lock: after reset, requester 1 sends a 3-beat packet (last on beat 3); requester 0 raises valid (last=1) during beat 2 → out_sel 1,1,1,0 and out_last 0,0,1,1. in_ready[0]=0 until the packet ends.
- Backpressure: out_ready=0 for 3 cycles while out_valid=1 → out_data/out_sel stable and in_ready=0000. Release → stream resumes with no lost or duplicated beat.
- X isolation: d3='x and in_valid[3]=0, only requester 0 valid, d0=7 → out_data=7 and never X. Abort mid-packet via rst_n → out_valid=0 and the next grant scans from requester 0.
